cdb_arbiter: RTL
================

// Module: cdb_arbiter
//
// PURPOSE
//  Shares the single common data bus (CDB) among the functional units (ALU, MDU, LSU, JMP).
//  Each unit presents a completed result with a valid/ready handshake.
//  The arbiter grants one unit per cycle using round-robin order.
//  It registers the winning packet onto the CDB, which drives ROB completion,
//  reservation-station wakeup and the physical register file write.
//
// PARAMETERS
//  NUM_REQ    4   number of requesting functional units (index = fu_id_t)
//  ROB_IDX_W  5   ROB index width
//  PREG_W     6   physical register index width
//  DATA_W     32  result data width
//
// PORTS
//  clk           in   1                    clock
//  rst           in   1                    synchronous active-high reset
//  flush         in   1                    pipeline flush (branch mispredict)
//  req_valid     in   NUM_REQ              unit i holds a completed result
//  req_pkt       in   NUM_REQ x cdb_t      per-unit packet {rob_idx, prd, rd, data}
//  req_ready     out  NUM_REQ              one-hot grant; transfer = valid & ready
//  cdb_valid     out  1                    CDB broadcast valid
//  cdb_pkt       out  cdb_t                broadcast packet
//  cdb_src       out  $clog2(NUM_REQ)      fu_id_t of the unit that produced cdb_pkt
//
// BEHAVIOUR
//  - Clock and reset: one clock. Reset is synchronous and active-high.
//  - Reset values:
//      - cdb_valid = 0, cdb_pkt = '0, cdb_src = 0, rr_ptr = 0.
//      - req_ready = 0 while rst = 1.
//  - Grant (combinational, same cycle):
//      - Scan i = rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//      - The first i with req_valid[i] = 1 gets req_ready[i] = 1.
//      - At most one ready bit is set at a time.
//  - Handshake rules:
//      - req_ready may depend on req_valid; req_valid must never depend on req_ready.
//      - A unit holds req_valid and a stable req_pkt until it sees valid & ready.
//      - No unit ever waits more than NUM_REQ-1 grants.
//  - Latency:
//      - The granted packet appears on cdb_pkt/cdb_valid on the next rising edge.
//      - Valid-to-broadcast = 1 cycle when the unit wins immediately.
//  - Register update on each edge, unless rst:
//      - cdb_valid <= |req_ready.
//      - cdb_pkt and cdb_src <= the winner's packet and index, only when a grant occurs.
//      - When there is no grant, cdb_pkt and cdb_src hold their values; only cdb_valid drops.
//  - Pointer update:
//      - On a grant to unit g, rr_ptr <= (g == NUM_REQ-1) ? 0 : g+1.
//      - With no grant, rr_ptr holds.
//  - Flush:
//      - While flush = 1: req_ready = 0 and no grant. Next cycle cdb_valid = 0; rr_ptr holds.
//      - A packet already registered when flush rises is still broadcast in that cycle
//        (it is visible before the flush edge).
//      - Units drop their own req_valid on flush; the arbiter keeps no per-request state.
//  - rd = 0 packets are broadcast normally; consumers suppress the x0 write.
//  - No backpressure from the CDB: the ROB and RS always accept the broadcast.
//  - Reset asserted mid-stream clears cdb_valid on that edge; a pending grant is discarded.
//  - NUM_REQ = 1 degenerates to ready = valid & ~flush, with rr_ptr fixed at 0.
//
// STRUCTURE
//  - Shared package rv32i_types gains:
//      - cdb_t: packed struct {rob_idx[ROB_IDX_W], prd[PREG_W], rd[5], data[DATA_W]}.
//      - fu_id_t: enum fu_alu=0, fu_mdu=1, fu_lsu=2, fu_jmp=3.
//  - Sub-module rr_arbiter #(N) holds the generic rotating-priority grant:
//      - inputs: req[N], ptr.
//      - outputs: gnt[N] one-hot, gnt_idx, any.
//      - Reused by issue selection elsewhere.
//  - cdb_arbiter adds flush gating, the pointer register and the output register.
//
// TESTING
//  1. Reset: rst=1 for 2 cycles with all req_valid=1
//     -> req_ready=0, cdb_valid=0; after release the first grant is fu_alu (ptr=0).
//  2. Single requester: req_valid=4'b0100, pkt {rob=3, prd=17, rd=5, data=32'hDEAD_BEEF}
//     -> req_ready=4'b0100 same cycle; next cycle cdb_valid=1, cdb_pkt equal, cdb_src=2.
//  3. All four requesting continuously with ptr=0
//     -> grants 0,1,2,3,0 on consecutive cycles; cdb_valid held at 1 for 5 cycles.
//  4. Pointer skip: ptr=1, req_valid=4'b1001
//     -> grant unit 3, ptr becomes 0; next cycle unit 0 granted.
//  5. Flush: unit 1 valid, flush=1 for 1 cycle
//     -> req_ready=0 and cdb_valid=0 next cycle, ptr unchanged;
//        a packet registered the prior cycle still broadcasts.
//  6. Idle gap: one grant then req_valid=0 for 3 cycles
//     -> cdb_valid=0, cdb_pkt holds its last value, ptr unchanged.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core types: the CDB broadcast packet and functional-unit ids.
package rv32i_types;

   localparam int ROB_IDX_W = 5;
   localparam int PREG_W    = 6;
   localparam int DATA_W    = 32;
   localparam int NUM_FU    = 4;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_idx;
      logic [PREG_W-1:0]    prd;
      logic [4:0]           rd;
      logic [DATA_W-1:0]    data;
   } cdb_t;

   typedef enum logic [1:0] {
      fu_alu = 2'd0,
      fu_mdu = 2'd1,
      fu_lsu = 2'd2,
      fu_jmp = 2'd3
   } fu_id_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic rotating-priority arbiter: the first requester at or after ptr
// (wrapping modulo N) wins. Purely combinational; the owner keeps the pointer.
module rr_arbiter #(
   parameter int  N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   always_comb begin
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!any && req[IW'(idx)]) begin
            gnt[IW'(idx)] = 1'b1;
            gnt_idx       = IW'(idx);
            any           = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional units, with the
// winning packet registered onto the CDB one cycle after the handshake.
module cdb_arbiter
   import rv32i_types::*;
#(
   parameter int  NUM_REQ = 4,
   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic [NUM_REQ-1:0] req_valid,
   input  cdb_t               req_pkt [NUM_REQ],
   output logic [NUM_REQ-1:0] req_ready,
   output logic               cdb_valid,
   output cdb_t               cdb_pkt,
   output logic [IDX_W-1:0]   cdb_src
);

   logic [NUM_REQ-1:0] req_elig;
   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_any;

   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               cdb_valid_q, cdb_valid_d;
   cdb_t               cdb_pkt_q, cdb_pkt_d;
   logic [IDX_W-1:0]   cdb_src_q, cdb_src_d;

   // Reset and flush mask requests before arbitration so no grant can leak out.
   always_comb begin
      req_elig = req_valid;
      if (rst || flush) begin
         req_elig = '0;
      end
   end

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req     (req_elig),
      .ptr     (rr_ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (gnt_any)
   );

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = gnt_any;
      cdb_pkt_d   = cdb_pkt_q;
      cdb_src_d   = cdb_src_q;
      if (gnt_any) begin
         cdb_pkt_d = req_pkt[gnt_idx];
         cdb_src_d = gnt_idx;
         rr_ptr_d  = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_pkt_q   <= '0;
         cdb_src_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_pkt_q   <= cdb_pkt_d;
         cdb_src_q   <= cdb_src_d;
      end
   end

   assign req_ready = gnt;
   assign cdb_valid = cdb_valid_q;
   assign cdb_pkt   = cdb_pkt_q;
   assign cdb_src   = cdb_src_q;

endmodule
